// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param. The overflow/underflow signals are
// present only when FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [LW-1:0]     level;
`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;
`endif

  modport master (
    output wr_en, wr_data, rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, level
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, level
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with registered read data, level and threshold flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              rd_acc;
  logic              wr_acc;
`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
`endif

  // A write into a full FIFO is legal only when a read frees a slot on the same edge.
  always_comb begin
    rd_acc      = bus.rd_en & ~empty_q;
    wr_acc      = bus.wr_en & (~full_q | rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
    end
    level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == LW'(0));
    af_d    = (level_d >= LW'(AF_THRESH));
    ae_d    = (level_d <= LW'(AE_THRESH));
`ifdef FIFO_ERR_FLAGS_EN
    overflow_d  = overflow_q  | (bus.wr_en & ~wr_acc);
    underflow_d = underflow_q | (bus.rd_en & ~rd_acc);
`endif
  end

  // Storage array is intentionally not reset; writes are blocked during reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
`ifdef FIFO_ERR_FLAGS_EN
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
`ifdef FIFO_ERR_FLAGS_EN
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`endif
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
`ifdef FIFO_ERR_FLAGS_EN
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
`endif
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, the next-generation buffer for byte and word streams between pipeline stages in the design. Width, depth and almost-full/almost-empty thresholds are configurable, and the occupancy level is exported. Write-when-full and read-when-empty requests are rejected rather than corrupting state; optional sticky error flags report them. Reads return registered data one cycle after acceptance, with an explicit valid strobe.

## Interface
- DATA_W, 8: data width in bits, ≥1
- DEPTH, 4: number of entries; power of two, ≥2
- AF_THRESH, DEPTH-1: almost_full asserts when level ≥ AF_THRESH; range 1..DEPTH
- AE_THRESH, 1: almost_empty asserts when level ≤ AE_THRESH; range 0..DEPTH-1
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse; rd_data holds the word from the read accepted in the previous cycle
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level ≥ AF_THRESH
- almost_empty  out  1  level ≤ AE_THRESH
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; present only with FIFO_ERR_FLAGS_EN
- underflow  out  1  sticky; present only with FIFO_ERR_FLAGS_EN

## Operation
- Storage: DEPTH×DATA_W array; not reset. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- rd_acc = rd_en & ~empty.
- wr_acc = wr_en & (~full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- When wr_acc: mem[wr_ptr] <= wr_data; wr_ptr increments.
- When rd_acc: rd_data <= mem[rd_ptr], using the pre-edge contents; rd_ptr increments; rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds.
- level_next = level + wr_acc − rd_acc, in $clog2(DEPTH)+1-bit arithmetic. It never leaves 0..DEPTH.
- full, empty, almost_full and almost_empty are registered and computed from level_next, so they are always consistent with level.
- Simultaneous read and write:
  - When empty: write accepted, read rejected. There is no bypass; the data becomes readable on the next cycle.
  - When full: both accepted; level stays at DEPTH.
  - Otherwise: both accepted; level unchanged.
- Rejected requests change no state other than the error flags.

## Timing
- Reset (rst_n == 0 at a clk edge) sets:
  - wr_ptr = 0, rd_ptr = 0, level = 0
  - empty = 1, full = 0
  - almost_empty = 1, almost_full = 0 (AF_THRESH ≥ 1)
  - rd_valid = 0, rd_data = 0
  - overflow = 0, underflow = 0
- Reset mid-operation discards all contents, and all of the above values apply on the following cycle. wr_en and rd_en are ignored during the reset cycle.
- Read latency: rd_en accepted at edge N gives rd_valid = 1 and valid rd_data after edge N, i.e. during cycle N+1.
- Write-to-read latency: word written at edge N is readable (empty = 0) in cycle N+1; its data appears after edge N+1 at the earliest.
- Flags and level update on the same edge as the accepted operation.
- Full throughput: one write and one read per cycle, sustained.

## Configuration
- FIFO_ERR_FLAGS_EN defined:
  - overflow sets on any cycle with wr_en & ~wr_acc.
  - underflow sets on any cycle with rd_en & ~rd_acc.
  - Both flags are sticky until reset.
- FIFO_ERR_FLAGS_EN undefined: the overflow and underflow ports and their logic are absent. Rejection behaviour is unchanged.

## Test plan
- DEPTH=4, DATA_W=8: reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> level 1,2,3,4; almost_full rises with level 3; full = 1 after the 4th write; empty = 0 after the 1st.
- From full, 4 consecutive reads -> rd_valid pulses in the 4 following cycles with rd_data 0x11,0x22,0x33,0x44; empty = 1 and almost_empty = 1 after the last read.
- Wrap-around: 10 write/read pairs with data 0x00..0x09, one write per cycle and reads lagging by 2 -> in-order output 0x00..0x09; level never exceeds 3.
- Full plus simultaneous read and write of 0x55 -> level stays 4; rd_data is the oldest word; 0x55 is read 4 reads later. Empty plus simultaneous read and write of 0x66 -> rd_valid = 0, level = 1.
- FIFO_ERR_FLAGS_EN defined: write 0x77 while full with rd_en = 0 -> overflow = 1, level stays 4, 0x77 is never read. Read when empty -> underflow = 1, rd_valid = 0.
- Reset asserted with level 3 -> next cycle level = 0, empty = 1, rd_valid = 0, error flags cleared; a following write of 0xAA then a read returns 0xAA.
